// File: rtl/fxp_pkg.sv
// Shared widths, rounding-mode encoding and saturation helper for the fixed-point multiplier.
package fxp_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  // Full word width: sign + integer + fraction bits.
  function automatic int unsigned fxp_w(input int unsigned q_m, input int unsigned q_n);
    return 1 + q_m + q_n;
  endfunction

  // Magnitude width: integer + fraction bits.
  function automatic int unsigned fxp_mw(input int unsigned q_m, input int unsigned q_n);
    return q_m + q_n;
  endfunction

  // All-ones magnitude of the given width, returned wide; callers cast to their width.
  function automatic logic [127:0] fxp_sat_mag(input int unsigned mw);
    return (128'(1) << mw) - 128'(1);
  endfunction

endpackage

// File: rtl/fxp_mul_lane.sv
// One lane of the sign-magnitude multiplier: S2 product register and S3 round/saturate/output register.
module fxp_mul_lane
  import fxp_pkg::*;
#(
  parameter int unsigned Q_M = 16,
  parameter int unsigned Q_N = 16,
  localparam int unsigned W  = fxp_w(Q_M, Q_N)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  round_mode_e rmode,
  output logic [W-1:0] y,
  output logic        ovf
);

  localparam int unsigned MW = fxp_mw(Q_M, Q_N);
  localparam int unsigned PW = 2 * MW;
  localparam int unsigned RW = PW + 1;
  localparam logic [MW-1:0] SAT_MAG  = MW'(fxp_sat_mag(MW));
  localparam logic [RW-1:0] HALF_LSB = RW'(1) << (Q_N - 1);

  logic [PW-1:0] prod_q;
  logic          sign_q;
  round_mode_e   rmode_q;

  logic [RW-1:0] rsum;
  logic [RW-1:0] rshift;
  logic          sat;
  logic [MW-1:0] mag;
  logic          sgn;

  // S2: magnitude product and result sign.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q  <= '0;
      sign_q  <= 1'b0;
      rmode_q <= RND_TRUNC;
    end else if (en) begin
      prod_q  <= PW'(a[MW-1:0]) * PW'(b[MW-1:0]);
      sign_q  <= a[W-1] ^ b[W-1];
      rmode_q <= rmode;
    end
  end

  // Round with one extra bit so the half-LSB carry survives, then saturate and clear negative zero.
  always_comb begin
    rsum   = RW'(prod_q) + ((rmode_q == RND_HALF_UP) ? HALF_LSB : '0);
    rshift = rsum >> Q_N;
    sat    = |rshift[RW-1:MW];
    mag    = sat ? SAT_MAG : rshift[MW-1:0];
    sgn    = (mag != '0) && sign_q;
  end

  // S3: registered lane result and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      y   <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      y   <= {sgn, mag};
      ovf <= sat;
    end
  end

endmodule

// File: rtl/fixed_point_mac_pipe.sv
// Three-stage, multi-lane sign-magnitude fixed-point multiplier with valid/ready backpressure.
module fixed_point_mac_pipe
  import fxp_pkg::*;
#(
  parameter int unsigned Q_M   = 16,
  parameter int unsigned Q_N   = 16,
  parameter int unsigned LANES = 1,
  localparam int unsigned W    = fxp_w(Q_M, Q_N)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               round_mode_i,
  input  logic [LANES*W-1:0] a_i,
  input  logic [LANES*W-1:0] b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [LANES*W-1:0] y_o,
  output logic [LANES-1:0]   ovf_o
);

  logic               en;
  logic               s1_valid;
  logic               s2_valid;
  logic [LANES*W-1:0] a_q;
  logic [LANES*W-1:0] b_q;
  round_mode_e        rmode_q;

  // Whole pipeline advances only when the output slot is empty or being drained.
  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en;

  // Stage valid bits; bubbles travel with the data and are never collapsed.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid_o <= 1'b0;
    end else if (en) begin
      s1_valid    <= in_valid_i;
      s2_valid    <= s1_valid;
      out_valid_o <= s2_valid;
    end
  end

  // S1: capture operands and rounding mode with the beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q     <= '0;
      b_q     <= '0;
      rmode_q <= RND_TRUNC;
    end else if (en) begin
      a_q     <= a_i;
      b_q     <= b_i;
      rmode_q <= round_mode_e'(round_mode_i);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fxp_mul_lane #(
      .Q_M(Q_M),
      .Q_N(Q_N)
    ) u_lane (
      .clk   (clk_i),
      .reset (reset_i),
      .en    (en),
      .a     (a_q[k*W +: W]),
      .b     (b_q[k*W +: W]),
      .rmode (rmode_q),
      .y     (y_o[k*W +: W]),
      .ovf   (ovf_o[k])
    );
  end

endmodule

// File: tb/tb_fixed_point_mac_pipe.sv
// Self-checking bench: Q16.16, a two-lane instance plus a one-lane instance fed from lane 0.
module tb_fixed_point_mac_pipe;

  typedef struct {
    logic [32:0] a0, b0, a1, b1;
    logic        rm;
    logic [32:0] y0, y1;
    logic        ov0, ov1;
  } vec_t;

  typedef struct {
    logic [65:0] y;
    logic [1:0]  ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        rm = 1'b0;
  logic [65:0] a = '0;
  logic [65:0] b = '0;
  logic        in_ready, out_valid;
  logic [65:0] y;
  logic [1:0]  ovf;
  logic        in_ready1, out_valid1;
  logic [32:0] y1;
  logic        ovf1;

  logic [65:0] exp_y_drv = '0;
  logic [1:0]  exp_ovf_drv = '0;
  exp_t        sb[$];
  vec_t        vecs[6];

  int          n_checks = 0;
  int          n_errs = 0;
  int          n_out = 0;
  logic        prev_stall = 1'b0;
  logic [65:0] prev_y = '0;
  logic [1:0]  prev_ovf = '0;

  always #5 clk = ~clk;

  fixed_point_mac_pipe #(.Q_M(16), .Q_N(16), .LANES(2)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .round_mode_i(rm), .a_i(a), .b_i(b), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .y_o(y), .ovf_o(ovf)
  );

  fixed_point_mac_pipe #(.Q_M(16), .Q_N(16), .LANES(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .round_mode_i(rm), .a_i(a[32:0]), .b_i(b[32:0]), .out_valid_o(out_valid1),
    .out_ready_i(out_ready), .y_o(y1), .ovf_o(ovf1)
  );

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference Q16.16 sign-magnitude multiply: returns {ovf, y}.
  function automatic logic [33:0] model(input logic [32:0] x, input logic [32:0] z, input logic rmode);
    logic [63:0] p;
    logic [64:0] s;
    logic [48:0] r;
    logic [31:0] m;
    logic        ov, sg;
    p  = 64'(x[31:0]) * 64'(z[31:0]);
    s  = 65'(p) + (rmode ? 65'h8000 : 65'h0);
    r  = s[64:16];
    ov = |r[48:32];
    m  = ov ? 32'hFFFF_FFFF : r[31:0];
    sg = (m != 32'h0) && (x[32] ^ z[32]);
    return {ov, sg, m};
  endfunction

  function automatic logic [32:0] rand_op();
    logic [31:0] m;
    m = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 15) == 0) m = 32'h0;
    return {1'($urandom_range(0, 1)), m};
  endfunction

  // Monitor: on the falling edge, pop/compare output transfers and push expected input transfers.
  always @(negedge clk) begin
    exp_t e;
    if (reset_i) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 66'(out_valid), 66'(1'b1));
        chk("stall_y", y, prev_y);
        chk("stall_ovf", 66'(ovf), 66'(prev_ovf));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 66'(in_ready), 66'(1'b0));
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errs++;
          $display("FAIL unexpected_beat: got y=%h with no beat outstanding at %0t", y, $time);
        end else begin
          e = sb.pop_front();
          chk("y", y, e.y);
          chk("ovf", 66'(ovf), 66'(e.ovf));
          chk("lane1build_valid", 66'(out_valid1), 66'(1'b1));
          chk("lane1build_y", 66'(y1), 66'(e.y[32:0]));
          chk("lane1build_ovf", 66'(ovf1), 66'(e.ovf[0]));
          n_out++;
        end
      end
      if (in_valid && in_ready) sb.push_back('{y: exp_y_drv, ovf: exp_ovf_drv});
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      prev_ovf   = ovf;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input vec_t v);
    a           = {v.a1, v.a0};
    b           = {v.b1, v.b0};
    rm          = v.rm;
    exp_y_drv   = {v.y1, v.y0};
    exp_ovf_drv = {v.ov1, v.ov0};
  endtask

  // One beat into an idle pipe; checks out_valid rises exactly 3 cycles after acceptance.
  task automatic send_one(input vec_t v);
    int lat;
    load_vec(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", 66'(lat), 66'(3));
    tick();
  endtask

  initial begin
    int k, n0;
    logic acc;
    logic [32:0] ra0, rb0, ra1, rb1;
    logic [33:0] r0, r1;

    vecs[0] = '{33'h0_0001_8000, 33'h0_0002_0000, 33'h1_0001_8000, 33'h0_0002_0000, 1'b0,
                33'h0_0003_0000, 33'h1_0003_0000, 1'b0, 1'b0};
    vecs[1] = '{33'h0_0000_0001, 33'h0_0000_8000, 33'h1_0000_0001, 33'h0_0000_8000, 1'b0,
                33'h0_0000_0000, 33'h0_0000_0000, 1'b0, 1'b0};
    vecs[2] = '{33'h0_0000_0001, 33'h0_0000_8000, 33'h1_0000_0001, 33'h0_0000_8000, 1'b1,
                33'h0_0000_0001, 33'h1_0000_0001, 1'b0, 1'b0};
    vecs[3] = '{33'h0_0100_0000, 33'h0_0100_0000, 33'h1_0100_0000, 33'h0_0100_0000, 1'b0,
                33'h0_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{33'h0_FFFF_FFFF, 33'h0_0001_0000, 33'h1_0000_0000, 33'h0_0001_0000, 1'b1,
                33'h0_FFFF_FFFF, 33'h0_0000_0000, 1'b0, 1'b0};
    vecs[5] = '{33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h1_0000_FFFF, 33'h1_0000_0001, 1'b0,
                33'h0_FFFF_FFFF, 33'h0_0000_0000, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    chk("rst_out_valid", 66'(out_valid), 66'(1'b0));
    chk("rst_y", y, 66'h0);
    chk("rst_ovf", 66'(ovf), 66'(2'b00));
    chk("rst_in_ready", 66'(in_ready), 66'(1'b1));
    tick();

    // Table-driven arithmetic vectors.
    for (int i = 0; i < 6; i++) send_one(vecs[i]);

    // Backpressure: 10 streamed beats, output stalled in cycles 4..8.
    n0 = n_out;
    k  = 1;
    rm = 1'b0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      if (k <= 10) begin
        in_valid    = 1'b1;
        a           = {2{33'(k << 16)}};
        b           = {2{33'h0_0002_0000}};
        exp_y_drv   = {2{33'((2 * k) << 16)}};
        exp_ovf_drv = 2'b00;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    out_ready = 1'b1;
    chk("bp_count", 66'(n_out - n0), 66'(10));
    chk("bp_drain", 66'(sb.size()), 66'(0));

    // Reset with three beats in flight and the output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_vec(vecs[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset_i  = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("midrst_out_valid", 66'(out_valid), 66'(1'b0));
    chk("midrst_y", y, 66'h0);
    chk("midrst_ovf", 66'(ovf), 66'(2'b00));
    chk("midrst_in_ready", 66'(in_ready), 66'(1'b1));
    out_ready = 1'b1;
    n0 = n_out;
    repeat (6) tick();
    chk("midrst_no_stale", 66'(n_out - n0), 66'(0));
    send_one(vecs[3]);

    // Full rate: 64 random beats back to back.
    n0 = n_out;
    for (int i = 0; i < 64; i++) begin
      ra0 = rand_op();
      rb0 = rand_op();
      ra1 = rand_op();
      rb1 = rand_op();
      rm  = 1'($urandom_range(0, 1));
      r0  = model(ra0, rb0, rm);
      r1  = model(ra1, rb1, rm);
      a           = {ra1, ra0};
      b           = {rb1, rb0};
      exp_y_drv   = {r1[32:0], r0[32:0]};
      exp_ovf_drv = {r1[33], r0[33]};
      in_valid    = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("rand_count", 66'(n_out - n0), 66'(64));
    chk("rand_drain", 66'(sb.size()), 66'(0));

    repeat (5) tick();
    chk("final_drain", 66'(sb.size()), 66'(0));
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
